muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_iter.sv | 133 +++++++++++++
 tb/tb_muldiv_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M-style multiply/divide unit: one radix-2 step per cycle,
// fixed latency for every operation and operand value.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   mag_a_reg, mag_b_reg;
  logic [XLEN-1:0]   acc_reg, lo_reg;
  logic [XLEN-1:0]   fix_reg, result_reg;
  logic              neg_a_reg, neg_b_reg, div0_reg;

  // operand decode at acceptance
  logic            signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign neg_a    = signed_a && src_a[XLEN-1];
  assign neg_b    = signed_b && src_b[XLEN-1];
  assign mag_a    = neg_a ? -src_a : src_a;
  assign mag_b    = neg_b ? -src_b : src_b;

  // {acc,lo} is the shifting product for multiply; acc=partial remainder,
  // lo=dividend shifting out / quotient shifting in for divide.
  logic [XLEN:0] mul_sum, div_r, div_diff;
  logic          div_ge;

  assign mul_sum  = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mag_a_reg} : {(XLEN+1){1'b0}});
  assign div_r    = {acc_reg, lo_reg[XLEN-1]};
  assign div_diff = div_r - {1'b0, mag_b_reg};
  assign div_ge   = !div_diff[XLEN];

  // sign correction and result selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fix_val;

  assign prod   = {acc_reg, lo_reg};
  assign prod_s = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
  assign quo    = div0_reg ? {XLEN{1'b1}} : ((neg_a_reg ^ neg_b_reg) ? -lo_reg : lo_reg);
  assign rem    = neg_a_reg ? -acc_reg : acc_reg;

  always_comb begin
    fix_val = rem;
    case (op_reg)
      3'b000:                 fix_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo;
      default:                fix_val = rem;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        if (flush)                             state_next = IDLE;
        else if (cnt_reg == CNT_W'(XLEN))      state_next = FIX;
      end
      FIX:  state_next = flush ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      acc_reg    <= '0;
      lo_reg     <= '0;
      fix_reg    <= '0;
      result_reg <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      div0_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          op_reg    <= op;
          mag_a_reg <= mag_a;
          mag_b_reg <= mag_b;
          neg_a_reg <= neg_a;
          neg_b_reg <= neg_b;
          div0_reg  <= (src_b == '0);
          acc_reg   <= '0;
          lo_reg    <= op[2] ? mag_a : mag_b;
          cnt_reg   <= '0;
        end
        CALC: if (!flush && cnt_reg != CNT_W'(XLEN)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (op_reg[2]) begin
            acc_reg <= div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0];
            lo_reg  <= {lo_reg[XLEN-2:0], div_ge};
          end else begin
            acc_reg <= mul_sum[XLEN:1];
            lo_reg  <= {mul_sum[0], lo_reg[XLEN-1:1]};
          end
        end
        FIX:  if (!flush) fix_reg <= fix_val;
        DONE: if (!flush) result_reg <= fix_reg;
        default: ;
      endcase
    end
  end

  // a flush landing on the DONE cycle hides both the pulse and the new value
  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE) && !flush;
  assign result = done ? fix_reg : result_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized self-checking bench for muldiv_iter against a 64-bit arithmetic model.
module tb_muldiv_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            flush = 1'b0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [XLEN-1:0] last_exp = '0;

  muldiv_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // launch one op, hold/garble start while busy, check latency and result,
  // then request again on the done cycle and verify it is ignored
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit rel_rst, input bit garble);
    int k;
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    op = f; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    if (garble) begin
      op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    end else start = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 4) start = 1'b0;
    end
    check("latency", k, 34);
    check("result", result, exp);
    $display("[TB] op=%0d a=%h b=%h result=%h expected=%h latency=%0d", f, a, b, result, exp, k);
    last_exp = exp;
    op = 3'($urandom); src_a = $urandom; src_b = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_ignored", busy, 0);
    check("result_held", result, exp);
  endtask

  logic [31:0] corner [5];

  function automatic logic [31:0] pick();
    int idx;
    idx = int'($urandom_range(0, 4));
    return ($urandom_range(0, 3) == 0) ? corner[idx] : $urandom;
  endfunction

  initial begin
    int snap;
    logic [2:0]  f;
    logic [31:0] a, b;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);

    // first op launched on the first edge with reset released
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 1'b0);

    // flush mid-divide, with a simultaneous start that must lose
    snap = done_cnt;
    @(negedge clk);
    op = 3'd4; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_result_kept", result, last_exp);
    check("flush_no_done", done_cnt, snap);
    do_op(3'd5, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);

    // async reset mid-multiply with start held high the whole time
    @(negedge clk);
    op = 3'd0; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_held_start", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    snap = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", done_cnt, snap);
    check("rst_stays_idle", busy, 0);

    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      do_op(f, a, b, ref_model(f, a, b), 1'b0, 1'(i % 3 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
